sin_lut_arbiter: RTL

//  Shares one sin_lut_n1024_16b read port between NUM_REQ requesters (e.g. per-qubit NCO/IQ lanes).
//  - Round-robin grant, one LUT read per cycle.
//  - Optional quarter-period offset per request (cosine).
//  - Returns LUT data to the granted requester after a fixed 2-cycle latency.

---
 rtl/sin_lut_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter_n.sv | 51 +++++
 rtl/sin_lut_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/sin_lut_ctrl_pkg.sv
// Shared constants and types for the sine-LUT read-port arbiter.
// The defaults describe a 1024-entry, 16-bit LUT shared by four requesters.
package sin_lut_ctrl_pkg;

  localparam int LUT_NUM_REQ    = 4;
  localparam int LUT_ADDR_WIDTH = 10;
  localparam int LUT_DATA_WIDTH = 16;
  localparam int NUM_ENTRY      = 1 << LUT_ADDR_WIDTH;
  localparam int QUARTER_OFFSET = NUM_ENTRY / 4;

  typedef logic [LUT_ADDR_WIDTH-1:0]      lut_addr_t;
  typedef logic [LUT_DATA_WIDTH-1:0]      lut_data_t;
  typedef logic [$clog2(LUT_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with a combinational one-hot grant.
// The pointer advances past the granted lane whenever a grant is issued.
module rr_arbiter_n #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;
  int              idx;

  // Search from the pointer upward, wrapping; the first requester wins.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int j = 0; j < N; j++) begin
      idx = (int'(rr_ptr_q) + j) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Shares one registered-read sine LUT port between NUM_REQ requesters.
// One read per cycle; data returns to the granted lane two cycles after accept.
module sin_lut_arbiter
  import sin_lut_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = LUT_NUM_REQ,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_cos,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         lut_rd_addr,
  input  logic [DATA_WIDTH-1:0]         lut_rd_data
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] QOFF = ADDR_WIDTH'(1 << (ADDR_WIDTH - 2));

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] eff_addr;

  logic [ADDR_WIDTH-1:0] lut_rd_addr_q, lut_rd_addr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]       s2_id_q, s2_id_d;
  logic [DATA_WIDTH-1:0] rsp_hold_q, rsp_hold_d;

  rr_arbiter_n #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Cosine is a quarter-period phase advance; the sum wraps modulo the table size.
  always_comb begin
    eff_addr = addr_arr[grant_id] + (req_cos[grant_id] ? QOFF : '0);
  end

  always_comb begin
    lut_rd_addr_d = grant_valid ? eff_addr : lut_rd_addr_q;
    s1_valid_d    = grant_valid;
    s1_id_d       = grant_valid ? grant_id : s1_id_q;
    s2_valid_d    = s1_valid_q;
    s2_id_d       = s1_id_q;
    rsp_hold_d    = s2_valid_q ? lut_rd_data : rsp_hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_rd_addr_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_id_q       <= '0;
      rsp_hold_q    <= '0;
    end else begin
      lut_rd_addr_q <= lut_rd_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      s2_valid_q    <= s2_valid_d;
      s2_id_q       <= s2_id_d;
      rsp_hold_q    <= rsp_hold_d;
    end
  end

  // The LUT output is live while a response is presented, otherwise the last one is held.
  assign lut_rd_addr = lut_rd_addr_q;
  assign rsp_valid   = s2_valid_q ? (NUM_REQ'(1) << s2_id_q) : '0;
  assign rsp_data    = s2_valid_q ? lut_rd_data : rsp_hold_q;

endmodule
